apb_requester: RTL and testbench



---
 rtl/apb_requester.sv | 161 ++++++++++++++++
 tb/tb_apb_requester.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// Single-outstanding APB-style requester: turns a valid/ready command into a
// SETUP/ACCESS bus transfer and returns the result on a one-entry response
// register with backpressure. ACCESS can be aborted by an optional timeout.
module apb_requester #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    // Command channel
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // Response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_wr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    // Bus
    output logic                  sel,
    output logic                  enable,
    output logic                  wr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy
);

    // A zero-width counter is illegal, so keep one bit when the timeout is off.
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StSetup  = 2'b01,
        StAccess = 2'b10
    } state_e;

    state_e                  state_q, state_d;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [CntW-1:0]         cnt_q, cnt_d;

    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_wr_q, rsp_wr_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                    accept;
    logic                    in_setup;
    logic                    in_access;
    logic                    done;
    logic                    timeout_hit;

    // Handshake and phase decode from registered state only.
    always_comb begin
        in_setup    = (state_q == StSetup);
        in_access   = (state_q == StAccess);
        cmd_ready   = (state_q == StIdle) && !rsp_valid_q;
        accept      = cmd_valid && cmd_ready;
        done        = in_access && ready;
        // ready on the last allowed cycle takes priority over the abort.
        timeout_hit = (TIMEOUT > 0) && in_access && !ready && (cnt_q == CntLast);
    end

    // Next-state logic; unused encodings fall back to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (done || timeout_hit) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Wait counter: cleared on accept, counts ACCESS cycles without ready, saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (in_access && !ready && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Response register next-state: load on completion or abort, clear on pop.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        if (done) begin
            rsp_valid_d = 1'b1;
            rsp_wr_d    = wr_q;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = wr_q ? '0 : rdata;
        end else if (timeout_hit) begin
            rsp_valid_d = 1'b1;
            rsp_wr_d    = wr_q;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State, counter and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Command latch, captured on accept and held for the whole transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            wr_q    <= cmd_wr;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
        end
    end

    // Bus drive: latched command only while a transfer is in flight, zero in idle.
    always_comb begin
        sel       = in_setup || in_access;
        enable    = in_access;
        busy      = sel;
        wr        = sel ? wr_q : 1'b0;
        addr      = sel ? addr_q : '0;
        wdata     = sel ? wdata_q : '0;
        rsp_valid = rsp_valid_q;
        rsp_wr    = rsp_wr_q;
        rsp_err   = rsp_err_q;
        rsp_rdata = rsp_rdata_q;
    end

endmodule

// File: tb/tb_apb_requester.sv
// Directed self-checking bench for apb_requester (default parameters).
module tb_apb_requester;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [4:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_wr;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       sel;
    logic       enable;
    logic       wr;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic       ready;
    logic [7:0] rdata;
    logic       busy;

    int n_pass;
    int n_total;

    apb_requester #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (5),
        .TIMEOUT    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_wr    (rsp_wr),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .sel       (sel),
        .enable    (enable),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int guard;
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        ready     = 1'b0;
        rdata     = '0;

        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst_sel", sel, 0);
        check("rst_enable", enable, 0);
        check("rst_wr", wr, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_wr", rsp_wr, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();

        // Write 0xA5 to addr 3; ready held high the whole time must be ignored until ACCESS.
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 5'd3;
        cmd_wdata = 8'hA5;
        ready     = 1'b1;
        rdata     = 8'h5A;
        check("wr_cmd_ready", cmd_ready, 1);
        step();                                  // edge N: accept
        cmd_valid = 1'b0;
        check("wr_setup_sel", sel, 1);
        check("wr_setup_en", enable, 0);
        check("wr_setup_busy", busy, 1);
        check("wr_setup_cmd_ready", cmd_ready, 0);
        step();                                  // edge N+1: ACCESS
        check("wr_acc_sel", sel, 1);
        check("wr_acc_en", enable, 1);
        check("wr_acc_wr", wr, 1);
        check("wr_acc_addr", addr, 3);
        check("wr_acc_wdata", wdata, 8'hA5);
        check("wr_acc_rsp_valid", rsp_valid, 0);
        step();                                  // edge N+2: response
        ready = 1'b0;
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_wr", rsp_wr, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_done_sel", sel, 0);
        check("wr_done_addr", addr, 0);
        check("wr_done_cmd_ready", cmd_ready, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("wr_pop_valid", rsp_valid, 0);
        check("wr_pop_cmd_ready", cmd_ready, 1);

        // Read addr 3 with four wait cycles, then rdata 0xA5.
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 5'd3;
        rdata     = 8'hFF;
        step();
        cmd_valid = 1'b0;
        check("rd_setup_en", enable, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("rd_wait_en", enable, 1);
            check("rd_wait_rsp_valid", rsp_valid, 0);
            step();
        end
        check("rd_last_en", enable, 1);
        ready = 1'b1;
        rdata = 8'hA5;
        step();
        ready = 1'b0;
        rdata = 8'h00;
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 8'hA5);
        check("rd_rsp_err", rsp_err, 0);
        check("rd_rsp_wr", rsp_wr, 0);
        check("rd_done_sel", sel, 0);
        check("rd_done_en", enable, 0);

        // Backpressure: response held 10 cycles, a pending command must wait.
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 5'd7;
        cmd_wdata = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, 8'hA5);
            check("bp_rsp_err", rsp_err, 0);
            check("bp_rsp_wr", rsp_wr, 0);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_sel", sel, 0);
            step();
        end
        rsp_ready = 1'b1;
        step();                                  // pop
        check("bp_pop_valid", rsp_valid, 0);
        check("bp_pop_cmd_ready", cmd_ready, 1);
        check("bp_pop_sel", sel, 0);
        check("bp_pop_rdata_held", rsp_rdata, 8'hA5);
        step();                                  // pending command accepted
        cmd_valid = 1'b0;
        ready     = 1'b1;
        check("bp_setup_sel", sel, 1);
        check("bp_setup_en", enable, 0);
        check("bp_setup_addr", addr, 7);
        check("bp_setup_wr", wr, 1);
        check("bp_setup_wdata", wdata, 8'h3C);
        step();
        check("bp_acc_en", enable, 1);
        step();
        ready = 1'b0;
        check("bp_rsp_valid2", rsp_valid, 1);
        check("bp_rsp_wr2", rsp_wr, 1);
        check("bp_rsp_rdata2", rsp_rdata, 0);
        step();                                  // rsp_ready still high: pop
        rsp_ready = 1'b0;
        check("bp_pop2", rsp_valid, 0);

        // Timeout: ready stuck low on a read.
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 5'h1F;
        rdata     = 8'h77;
        step();
        cmd_valid = 1'b0;
        step();
        n     = 0;
        guard = 0;
        while (rsp_valid !== 1'b1 && guard < 40) begin
            if (sel && enable) n++;
            step();
            guard++;
        end
        check("to_access_cycles", n, 16);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        check("to_rsp_wr", rsp_wr, 0);
        check("to_sel", sel, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("to_pop", rsp_valid, 0);

        // ready arriving on the 16th ACCESS cycle completes normally.
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();                                  // ACCESS cycle 1
        for (int i = 0; i < 15; i++) step();     // now in cycle 16
        check("to16_en", enable, 1);
        check("to16_rsp_valid", rsp_valid, 0);
        ready = 1'b1;
        rdata = 8'h3C;
        step();
        ready = 1'b0;
        check("to16_rsp_valid2", rsp_valid, 1);
        check("to16_rsp_err", rsp_err, 0);
        check("to16_rsp_rdata", rsp_rdata, 8'h3C);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset asserted mid-ACCESS.
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 5'd9;
        cmd_wdata = 8'h11;
        step();
        cmd_valid = 1'b0;
        step();
        check("mr_in_access", enable, 1);
        #2 reset = 1'b1;
        #1;
        check("mr_sel", sel, 0);
        check("mr_en", enable, 0);
        check("mr_addr", addr, 0);
        check("mr_wdata", wdata, 0);
        check("mr_wr", wr, 0);
        check("mr_busy", busy, 0);
        ready = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        ready = 1'b0;
        step();
        check("mr_no_rsp", rsp_valid, 0);
        check("mr_idle_sel", sel, 0);
        check("mr_cmd_ready", cmd_ready, 1);

        // New write after reset.
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 5'd4;
        cmd_wdata = 8'h66;
        step();
        cmd_valid = 1'b0;
        ready     = 1'b1;
        step();
        check("pr_acc_addr", addr, 4);
        check("pr_acc_wdata", wdata, 8'h66);
        step();
        ready = 1'b0;
        check("pr_rsp_valid", rsp_valid, 1);
        check("pr_rsp_wr", rsp_wr, 1);
        check("pr_rsp_err", rsp_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
